// File: rtl/pdcch_rx_pkg.sv
// Shared types for the PDCCH receive chain: complex angle sample, repeater
// config word, repeater FSM states and a saturating negate helper.
package pdcch_rx_pkg;

    localparam int DW = 24;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic       conj_en;
        logic [5:0] rep_cnt;
        logic [1:0] ant_m1;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    // Two's complement negate that maps the most negative value to the most positive one.
    function automatic logic signed [DW-1:0] sat_neg(input logic signed [DW-1:0] x);
        logic signed [DW-1:0] r;
        if (x == {1'b1, {(DW-1){1'b0}}}) begin
            r = {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = -x;
        end
        return r;
    endfunction

endpackage

// File: rtl/pdcch_offset_angle_repeater.sv
// Captures one angle sample per active antenna per config, replays the set rep_cnt times (imag optionally conjugated).
// Latency: first output beat valid the cycle after the last input beat is accepted; 1 beat/clk while data_out_tready=1.
// Backpressure: registered output holds while stalled; config/data tready low outside IDLE/LOAD, nothing is dropped.
module pdcch_offset_angle_repeater
    import pdcch_rx_pkg::*;
#(
    parameter int nRx = 2,
    parameter int DW  = pdcch_rx_pkg::DW
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [8:0]      config_in_tdata,
    input  logic            config_in_tvalid,
    output logic            config_in_tready,
    input  logic [2*DW-1:0] data_in_tdata,
    input  logic            data_in_tvalid,
    output logic            data_in_tready,
    input  logic            data_in_tlast,
    output logic [2*DW-1:0] data_out_tdata,
    output logic            data_out_tvalid,
    input  logic            data_out_tready,
    output logic            data_out_tlast
);

    localparam int KW = (nRx > 1) ? $clog2(nRx) : 1;

    state_t          state;
    state_t          state_nxt;

    logic            cfg_rdy;
    logic            din_rdy;
    logic            conj_en;
    logic [6:0]      rep_tot;
    logic [KW-1:0]   ant_last;
    logic [KW-1:0]   wr_idx;
    logic [KW-1:0]   rd_k;
    logic [5:0]      rd_r;
    logic            issue_done;
    cplx_t           sbuf [nRx];

    cplx_t           out_dat;
    logic            out_vld;
    logic            out_lst;

    cfg_t            cfg_w;
    cplx_t           din_w;
    logic            cfg_acc;
    logic            din_acc;
    logic            dout_acc;
    logic            load_last;
    logic            out_free;
    logic [KW-1:0]   cfg_last;
    int              ant_n;

    logic            ld_en;
    logic            ld_lst;
    cplx_t           ld_src;
    cplx_t           ld_dat;
    logic [KW-1:0]   ld_k;
    logic [5:0]      ld_r;
    logic [KW-1:0]   ld_alast;
    logic [KW-1:0]   nxt_k;
    logic [5:0]      nxt_r;

    assign cfg_w     = cfg_t'(config_in_tdata);
    assign din_w     = {data_in_tdata[DW-1:0], data_in_tdata[2*DW-1:DW]};
    assign cfg_acc   = config_in_tvalid && cfg_rdy;
    assign din_acc   = data_in_tvalid && din_rdy;
    assign dout_acc  = out_vld && data_out_tready;
    assign load_last = din_acc && ((wr_idx == ant_last) || data_in_tlast);
    assign out_free  = !out_vld || data_out_tready;

    assign config_in_tready = cfg_rdy;
    assign data_in_tready   = din_rdy;
    assign data_out_tvalid  = out_vld;
    assign data_out_tlast   = out_lst;
    assign data_out_tdata   = {out_dat.im, out_dat.re};

    always_comb begin
        ant_n = int'(cfg_w.ant_m1) + 1;
        if (ant_n > nRx) begin
            ant_n = nRx;
        end
        cfg_last = KW'(ant_n - 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cfg_acc) state_nxt = LOAD;
            LOAD: if (load_last) state_nxt = PLAY;
            PLAY: if (dout_acc && out_lst) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first beat bypasses the buffer so playback starts the cycle after the final capture.
    always_comb begin
        ld_en    = 1'b0;
        ld_src   = '0;
        ld_k     = '0;
        ld_r     = '0;
        ld_alast = '0;
        if (state == LOAD && load_last) begin
            ld_en    = 1'b1;
            ld_src   = (wr_idx == '0) ? din_w : sbuf[0];
            ld_alast = wr_idx;
        end else if (state == PLAY && out_free && !issue_done) begin
            ld_en    = 1'b1;
            ld_src   = sbuf[rd_k];
            ld_k     = rd_k;
            ld_r     = rd_r;
            ld_alast = ant_last;
        end
        ld_lst = ld_en && (ld_k == ld_alast) && ({1'b0, ld_r} == rep_tot - 7'd1);
        if (ld_k == ld_alast) begin
            nxt_k = '0;
            nxt_r = ld_r + 6'd1;
        end else begin
            nxt_k = ld_k + KW'(1);
            nxt_r = ld_r;
        end
        ld_dat.re = ld_src.re;
        ld_dat.im = conj_en ? sat_neg(ld_src.im) : ld_src.im;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            cfg_rdy    <= 1'b0;
            din_rdy    <= 1'b0;
            conj_en    <= 1'b0;
            rep_tot    <= 7'd1;
            ant_last   <= '0;
            wr_idx     <= '0;
            rd_k       <= '0;
            rd_r       <= '0;
            issue_done <= 1'b0;
            out_vld    <= 1'b0;
            out_lst    <= 1'b0;
            out_dat    <= '0;
        end else begin
            state   <= state_nxt;
            cfg_rdy <= (state_nxt == IDLE);
            din_rdy <= (state_nxt == LOAD);
            if (cfg_acc) begin
                conj_en  <= cfg_w.conj_en;
                rep_tot  <= (cfg_w.rep_cnt == 6'd0) ? 7'd64 : {1'b0, cfg_w.rep_cnt};
                ant_last <= cfg_last;
                wr_idx   <= '0;
            end
            if (din_acc) begin
                wr_idx <= wr_idx + KW'(1);
                if (load_last) begin
                    ant_last <= wr_idx;
                end
            end
            if (ld_en) begin
                out_vld    <= 1'b1;
                out_lst    <= ld_lst;
                out_dat    <= ld_dat;
                rd_k       <= nxt_k;
                rd_r       <= nxt_r;
                issue_done <= ld_lst;
            end else if (state == PLAY && out_free) begin
                out_vld <= 1'b0;
                out_lst <= 1'b0;
            end
        end
    end

    // Sample storage carries no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (din_acc) begin
            sbuf[wr_idx] <= din_w;
        end
    end

endmodule

// File: tb/tb_pdcch_offset_angle_repeater.sv
// Directed table of repeater blocks with hand-computed results, plus reset-mid-play
// and randomly throttled blocks checked against a small reference model.
module tb_pdcch_offset_angle_repeater;

    localparam int DW    = 24;
    localparam int LIMIT = 5000;

    typedef struct packed {
        logic              conj;
        logic [5:0]        rep;
        logic [1:0]        ant_m1;
        logic [31:0]       n_in;
        logic [1:0][47:0]  din;
        logic [1:0]        tl;
        logic              extra;
        logic              tp;
        logic [31:0]       exp_a;
        logic [31:0]       exp_n;
        logic [1:0][47:0]  exp_s;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [8:0]      config_in_tdata;
    logic            config_in_tvalid;
    logic            config_in_tready;
    logic [2*DW-1:0] data_in_tdata;
    logic            data_in_tvalid;
    logic            data_in_tready;
    logic            data_in_tlast;
    logic [2*DW-1:0] data_out_tdata;
    logic            data_out_tvalid;
    logic            data_out_tready;
    logic            data_out_tlast;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;
    int last_in_cyc = 0;
    int n_in_acc = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    pdcch_offset_angle_repeater #(.nRx(2), .DW(DW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .config_in_tdata  (config_in_tdata),
        .config_in_tvalid (config_in_tvalid),
        .config_in_tready (config_in_tready),
        .data_in_tdata    (data_in_tdata),
        .data_in_tvalid   (data_in_tvalid),
        .data_in_tready   (data_in_tready),
        .data_in_tlast    (data_in_tlast),
        .data_out_tdata   (data_out_tdata),
        .data_out_tvalid  (data_out_tvalid),
        .data_out_tready  (data_out_tready),
        .data_out_tlast   (data_out_tlast)
    );

    always @(posedge clk) begin
        if (data_in_tvalid && data_in_tready) begin
            last_in_cyc <= cyc_cnt;
            n_in_acc    <= n_in_acc + 1;
        end
        cyc_cnt <= cyc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int n);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no handshake after %0d cycles, required fewer than %0d", nm, n, LIMIT);
    endtask

    function automatic logic [23:0] ref_neg(input logic [23:0] x);
        if (x == 24'h800000) return 24'h7FFFFF;
        return 24'(~x + 24'd1);
    endfunction

    function automatic vec_t mk(input logic conj, input int rep, input logic [1:0] ant_m1, input int n_in,
                                input logic [47:0] d0, input logic [47:0] d1, input logic tl0, input logic tl1,
                                input logic extra, input logic tp, input int ea, input int en,
                                input logic [47:0] e0, input logic [47:0] e1);
        vec_t v;
        v = '0;
        v.conj = conj; v.rep = 6'(rep); v.ant_m1 = ant_m1; v.n_in = 32'(n_in);
        v.din[0] = d0; v.din[1] = d1; v.tl[0] = tl0; v.tl[1] = tl1;
        v.extra = extra; v.tp = tp; v.exp_a = 32'(ea); v.exp_n = 32'(en);
        v.exp_s[0] = e0; v.exp_s[1] = e1;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        logic [47:0] d;
        int a;
        bit early;
        v = '0;
        v.conj   = 1'($urandom_range(0, 1));
        v.rep    = 6'($urandom_range(1, 4));
        v.ant_m1 = 2'($urandom_range(0, 3));
        a = int'(v.ant_m1) + 1;
        if (a > 2) a = 2;
        early = (a == 2) && ($urandom_range(0, 3) == 0);
        if (early) a = 1;
        for (int i = 0; i < a; i++) begin
            d[23:0]  = 24'($urandom);
            d[47:24] = ($urandom_range(0, 3) == 0) ? 24'h800000 : 24'($urandom);
            v.din[i] = d;
            v.tl[i]  = (i == a - 1) ? (early ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
            v.exp_s[i] = v.conj ? {ref_neg(d[47:24]), d[23:0]} : d;
        end
        v.n_in  = 32'(a);
        v.exp_a = 32'(a);
        v.exp_n = 32'(a * int'(v.rep));
        return v;
    endfunction

    task automatic send_cfg(input logic [8:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        config_in_tdata  = d;
        config_in_tvalid = 1'b1;
        n = 0;
        while (!config_in_tready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) timeout("cfg_wait", n);
        @(negedge clk);
        config_in_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [47:0] d, input logic tl, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        data_in_tdata  = d;
        data_in_tlast  = tl;
        data_in_tvalid = 1'b1;
        n = 0;
        while (!data_in_tready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) timeout("data_wait", n);
        @(negedge clk);
        data_in_tvalid = 1'b0;
        data_in_tlast  = 1'b0;
    endtask

    task automatic recv(input vec_t v, input bit thr);
        int got, n, gap_left, bubbles, first_cyc;
        bit rdy, stall_prev;
        logic [48:0] held;
        logic [47:0] e;
        got = 0; n = 0; bubbles = 0; first_cyc = 0; stall_prev = 0; held = '0;
        gap_left = thr ? $urandom_range(0, 9) : 0;
        while (got < int'(v.exp_n) && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (gap_left > 0) begin
                rdy = 1'b0;
                gap_left--;
            end else begin
                rdy = 1'b1;
            end
            data_out_tready = rdy;
            if (stall_prev) begin
                chk("hold_tvalid", 64'(data_out_tvalid), 64'd1);
                chk("hold_tdata_tlast", 64'({data_out_tlast, data_out_tdata}), 64'(held));
            end
            stall_prev = 1'b0;
            if (data_out_tvalid) begin
                if (got == 0) first_cyc = cyc_cnt;
                if (rdy) begin
                    e = ((got % int'(v.exp_a)) == 0) ? v.exp_s[0] : v.exp_s[1];
                    chk("beat_tdata", 64'(data_out_tdata), 64'(e));
                    chk("beat_tlast", 64'(data_out_tlast), (got == int'(v.exp_n) - 1) ? 64'd1 : 64'd0);
                    got++;
                    gap_left = thr ? $urandom_range(0, 9) : 0;
                end else begin
                    stall_prev = 1'b1;
                    held = {data_out_tlast, data_out_tdata};
                end
            end else if (got > 0) begin
                bubbles++;
            end
        end
        if (got < int'(v.exp_n)) timeout("output_beats", n);
        if (v.tp) begin
            chk("no_bubbles", 64'(bubbles), 64'd0);
            chk("first_out_latency", 64'(first_cyc - last_in_cyc), 64'd1);
        end
        @(negedge clk);
        chk("tvalid_after_block", 64'(data_out_tvalid), 64'd0);
    endtask

    task automatic run_block(input vec_t v, input bit thr);
        int n0;
        n0 = n_in_acc;
        fork
            begin
                send_cfg({v.conj, v.rep, v.ant_m1}, thr ? $urandom_range(0, 9) : 0);
                for (int i = 0; i < int'(v.n_in); i++) begin
                    send_beat(v.din[i], v.tl[i], thr ? $urandom_range(0, 9) : 0);
                end
                if (v.extra) begin
                    int cnt;
                    cnt = 0;
                    data_in_tdata  = 48'hDEAD00BEEF00;
                    data_in_tvalid = 1'b1;
                    repeat (4) begin
                        if (data_in_tready) cnt++;
                        @(negedge clk);
                    end
                    data_in_tvalid = 1'b0;
                    chk("no_extra_input_accept", 64'(cnt), 64'd0);
                end
            end
            recv(v, thr);
        join
        chk("input_beats_accepted", 64'(n_in_acc - n0), 64'(v.exp_a));
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(0, 3, 2'd1, 2, {24'h200000, 24'h100000}, {24'hE00000, 24'h300000}, 0, 1, 0, 1, 2, 6,
                    {24'h200000, 24'h100000}, {24'hE00000, 24'h300000});
        tbl[1] = mk(1, 1, 2'd0, 1, {24'h800000, 24'h123456}, 48'h0, 1, 0, 0, 0, 1, 1,
                    {24'h7FFFFF, 24'h123456}, 48'h0);
        tbl[2] = mk(0, 0, 2'd0, 1, {24'h654321, 24'h0ABCDE}, 48'h0, 1, 0, 0, 1, 1, 64,
                    {24'h654321, 24'h0ABCDE}, 48'h0);
        tbl[3] = mk(0, 2, 2'd1, 1, {24'hFFF000, 24'h000111}, 48'h0, 1, 0, 1, 0, 1, 2,
                    {24'hFFF000, 24'h000111}, 48'h0);
        tbl[4] = mk(1, 2, 2'd1, 2, {24'h000001, 24'h7FFFFF}, {24'h7FFFFF, 24'h800000}, 0, 0, 0, 1, 2, 4,
                    {24'hFFFFFF, 24'h7FFFFF}, {24'h800001, 24'h800000});
        tbl[5] = mk(0, 1, 2'd3, 2, {24'h000002, 24'h000001}, {24'h000004, 24'h000003}, 0, 0, 0, 0, 2, 2,
                    {24'h000002, 24'h000001}, {24'h000004, 24'h000003});

        rstn = 1'b1;
        config_in_tdata = '0; config_in_tvalid = 1'b0;
        data_in_tdata = '0; data_in_tvalid = 1'b0; data_in_tlast = 1'b0;
        data_out_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_config_in_tready", 64'(config_in_tready), 64'd0);
        chk("rst_data_in_tready", 64'(data_in_tready), 64'd0);
        chk("rst_data_out_tvalid", 64'(data_out_tvalid), 64'd0);
        chk("rst_data_out_tlast", 64'(data_out_tlast), 64'd0);
        chk("rst_data_out_tdata", 64'(data_out_tdata), 64'd0);
        rstn = 1'b0;
        @(negedge clk);
        chk("idle_config_in_tready", 64'(config_in_tready), 64'd1);
        chk("idle_data_in_tready", 64'(data_in_tready), 64'd0);

        for (int i = 0; i < 6; i++) run_block(tbl[i], 1'b0);

        // Reset while beat 3 of 6 is on the output.
        fork
            begin
                send_cfg({tbl[0].conj, tbl[0].rep, tbl[0].ant_m1}, 0);
                send_beat(tbl[0].din[0], 1'b0, 0);
                send_beat(tbl[0].din[1], 1'b1, 0);
            end
            begin
                int got, n;
                got = 0; n = 0;
                data_out_tready = 1'b1;
                while (got < 2 && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                    if (data_out_tvalid) got++;
                end
                if (got < 2) timeout("mid_play_beats", n);
                @(negedge clk);
                chk("mid_play_beat3_tvalid", 64'(data_out_tvalid), 64'd1);
                chk("mid_play_beat3_tdata", 64'(data_out_tdata), 64'(tbl[0].exp_s[0]));
                rstn = 1'b1;
                #1;
                chk("abort_tvalid", 64'(data_out_tvalid), 64'd0);
                chk("abort_tlast", 64'(data_out_tlast), 64'd0);
                chk("abort_tdata", 64'(data_out_tdata), 64'd0);
                chk("abort_config_in_tready", 64'(config_in_tready), 64'd0);
                chk("abort_data_in_tready", 64'(data_in_tready), 64'd0);
            end
        join
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        run_block(tbl[1], 1'b0);
        run_block(tbl[0], 1'b0);

        for (int i = 0; i < 20; i++) begin
            v = rnd_vec();
            run_block(v, 1'b0);
            run_block(v, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
